// File: rtl/coll_accum_ctrl.sv
// Sequencing controller around the shared 64-bit adder: accumulates NUM_TERMS terms,
// then subtract-compares against the frame threshold. Optional macro: COLL_SAT_EN (saturating accumulate).
//
// state | meaning
// ACC   | accepting terms, acc <= acc + s_data
// CMP   | one cycle, adder computes acc - thr_q, hit captured from carry-out
// OUT   | result presented on m_*, waits for m_ready
module coll_accum_ctrl #(
  parameter int NUM_TERMS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [63:0] s_data,
  input  logic [63:0] thresh,
  output logic [63:0] add_a,
  output logic [63:0] add_b,
  output logic        add_cin,
  input  logic [63:0] add_s,
  input  logic        add_cout,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_sum,
  output logic        m_ovf,
  output logic        m_hit
);

  typedef enum logic [1:0] {ACC, CMP, OUT} state_t;

  localparam logic [7:0] LAST = 8'(NUM_TERMS - 1);

  state_t      state, state_nxt;
  logic [63:0] acc, acc_upd;
  logic        ovf;
  logic [7:0]  cnt;
  logic [63:0] thr_q;
  logic        hit;
  logic        take;

  assign take  = s_valid & s_ready;
  assign m_sum = acc;
  assign m_ovf = ovf;
  assign m_hit = hit;

  always_comb begin
`ifdef COLL_SAT_EN
    // once any carry has been seen the frame sum is pinned at all-ones
    acc_upd = (add_cout | ovf) ? '1 : add_s;
`else
    acc_upd = add_s;
`endif
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    add_a     = acc;
    add_b     = '0;
    add_cin   = 1'b0;
    case (state)
      ACC: begin
        s_ready = ~rst;
        add_b   = s_data;
        if (take && cnt == LAST) state_nxt = CMP;
      end
      CMP: begin
        // acc + ~thr + 1 == acc - thr; carry-out set iff acc >= thr
        add_b     = ~thr_q;
        add_cin   = 1'b1;
        state_nxt = OUT;
      end
      OUT: begin
        m_valid = ~rst;
        if (m_valid && m_ready) state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
      thr_q <= '0;
      hit   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ACC: begin
          if (take) begin
            acc <= acc_upd;
            ovf <= ovf | add_cout;
            cnt <= cnt + 8'd1;
            if (cnt == 8'd0) thr_q <= thresh;
          end
        end
        CMP: hit <= ~add_cout & ~ovf;
        OUT: begin
          if (m_valid && m_ready) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
